// File: rtl/sprinkler_pkg.sv
// Shared definitions for the sprinkler tens-digit controller: FSM encoding,
// BCD limits and active-low seven-segment patterns (bit order {g,f,e,d,c,b,a}).
package sprinkler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10,
        ST_REARM = 2'b11
    } state_e;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Non-BCD codes render as blank rather than a garbage glyph.
    function automatic logic [6:0] seg7_encode(input logic [BCD_W-1:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sprinkler_tens_controller_if.sv
// Request/sensor and valve/display signals of the tens controller.
// Seven-segment outputs exist only when SPRINKLER_SEG7_EN is defined.
interface sprinkler_tens_controller_if #(
    parameter int unsigned UNIT_WIDTH = 4
);
    logic                  start;
    logic                  stop;
    logic [UNIT_WIDTH-1:0] unit_digit;
    logic                  unit_borrow;
    logic                  load_units;
    logic [UNIT_WIDTH-1:0] tens_digit;
    logic                  valve_on;
    logic                  done;
    logic                  aborted;
    logic [1:0]            state;
`ifdef SPRINKLER_SEG7_EN
    logic [6:0]            seg_tens;
    logic [6:0]            seg_units;
`endif

    modport master (
`ifdef SPRINKLER_SEG7_EN
        input  seg_tens,
        input  seg_units,
`endif
        output start,
        output stop,
        output unit_digit,
        output unit_borrow,
        input  load_units,
        input  tens_digit,
        input  valve_on,
        input  done,
        input  aborted,
        input  state
    );

    modport slave (
`ifdef SPRINKLER_SEG7_EN
        output seg_tens,
        output seg_units,
`endif
        input  start,
        input  stop,
        input  unit_digit,
        input  unit_borrow,
        output load_units,
        output tens_digit,
        output valve_on,
        output done,
        output aborted,
        output state
    );

endinterface

// File: rtl/sprinkler_edge_detect.sv
// One-bit rising-edge detector: a level held for many cycles yields one pulse.
module sprinkler_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/sprinkler_tens_controller.sv
// Tens digit of remaining irrigation time plus the irrigation FSM (valve, load, done).
// Optional seven-segment display outputs are enabled by SPRINKLER_SEG7_EN.
module sprinkler_tens_controller
    import sprinkler_pkg::*;
#(
    parameter logic [3:0]  DURATION_TENS = 4'd3,
    parameter int unsigned UNIT_WIDTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    sprinkler_tens_controller_if.slave  bus
);

    if (DURATION_TENS > BCD_MAX) begin : g_bad_duration
        $error("DURATION_TENS must be a BCD digit (0-9)");
    end
    if (UNIT_WIDTH != BCD_W) begin : g_bad_width
        $error("UNIT_WIDTH must equal the BCD digit width");
    end

    logic start_rise;
    logic borrow_rise;

    sprinkler_edge_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.start),
        .rise  (start_rise)
    );

    sprinkler_edge_detect u_borrow_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.unit_borrow),
        .rise  (borrow_rise)
    );

    state_e           state_q, state_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic             aborted_q, aborted_d;
    logic             load_d, load_q;
    logic             valve_q;
    logic             done_q;

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        aborted_d = aborted_q;
        load_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise && !bus.stop) begin
                    state_d   = ST_RUN;
                    tens_d    = DURATION_TENS;
                    load_d    = 1'b1;
                    aborted_d = 1'b0;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident borrow and freezes the digit.
                if (bus.stop) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (borrow_rise) begin
                    if (tens_q != '0) begin
                        tens_d = tens_q - 4'd1;
                    end else begin
                        state_d = ST_DONE;
                        tens_d  = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_REARM;
            end
            ST_REARM: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // valve_on and done decode the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tens_q    <= '0;
            aborted_q <= 1'b0;
            load_q    <= 1'b0;
            valve_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            aborted_q <= aborted_d;
            load_q    <= load_d;
            valve_q   <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign bus.load_units = load_q;
    assign bus.tens_digit = tens_q;
    assign bus.valve_on   = valve_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.state      = state_q;

`ifdef SPRINKLER_SEG7_EN
    logic [6:0] seg_tens_q;
    logic [6:0] seg_units_q;
    logic       seg_show;

    // Display tracks the valve, plus the DONE cycle so the final digits are visible.
    assign seg_show = (state_d == ST_RUN) || (state_d == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_tens_q  <= SEG_BLANK;
            seg_units_q <= SEG_BLANK;
        end else begin
            seg_tens_q  <= seg_show ? seg7_encode(tens_q) : SEG_BLANK;
            seg_units_q <= seg_show ? seg7_encode(bus.unit_digit) : SEG_BLANK;
        end
    end

    assign bus.seg_tens  = seg_tens_q;
    assign bus.seg_units = seg_units_q;
`else
    logic unused_unit_digit;
    assign unused_unit_digit = ^bus.unit_digit;
`endif

endmodule

// File: doc/sprinkler_tens_controller.md
Name: sprinkler_tens_controller

Overview:
- Downstream stage of the sprinkler unit (seconds) counter. Consumes its BCD units digit and its borrow pulse (the units counter's outClock), and keeps the tens digit of the remaining irrigation time.
- Runs the irrigation state machine: loads the units counter, drives the valve, and signals completion.
- Sits between the irrigation request/sensor logic and the valve/display outputs.

Parameters:
- DURATION_TENS, 4'd3, BCD tens value loaded at cycle start (0–9). Values above 9 are illegal; elaboration fails on them.
- UNIT_WIDTH, 4, width of the BCD digit buses.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  irrigation request (level); a cycle starts on its rising edge
- stop  in  1  abort request (level), e.g. reservoir low; sampled synchronously
- unit_digit  in  4  BCD units digit from the units counter (status/display only)
- unit_borrow  in  1  units counter borrow (outClock); only its rising edge counts
- load_units  out  1  one-cycle pulse; presets the units counter
- tens_digit  out  4  BCD tens of remaining time
- valve_on  out  1  sprinkler valve drive
- done  out  1  one-cycle pulse when a cycle ends (expiry or abort)
- aborted  out  1  high with done when the end was caused by stop; held until the next start
- state  out  2  current FSM state: IDLE=00, RUN=01, DONE=10, REARM=11

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, tens_digit=0, valve_on=0, load_units=0, done=0, aborted=0, edge-detector history registers=0.
- Edge detection: registered previous values of start and unit_borrow; event = current & ~previous. A level held for N cycles counts once.
- IDLE: on a start edge with stop=0: tens_digit<=DURATION_TENS, load_units=1 for exactly that cycle, aborted<=0, go to RUN. valve_on rises the same edge (latency 1 clk from the start edge). A start edge while stop=1 is ignored.
- RUN: valve_on=1.
  - Borrow edge with tens_digit>0: tens_digit<=tens_digit-1, BCD decrement with no wrap.
  - Borrow edge with tens_digit==0: time expired; go to DONE and set tens_digit<=0.
  - stop=1: go to DONE, aborted<=1. stop has priority over a simultaneous borrow edge, and tens_digit is frozen.
  - A start edge in RUN is ignored (no restart).
- DONE: a single cycle. valve_on=0, done=1, then go to REARM.
- REARM: wait for start=0, then go to IDLE. This prevents an auto-restart while the request is held.
- valve_on is a registered decode of state==RUN. It has no combinational path from any input.
- load_units is registered and never asserted outside the IDLE→RUN transition.
- tens_digit never exceeds 9. It never underflows (at 0 the borrow ends the cycle).
- unit_digit does not affect control flow. It is passed only to the optional display logic.
- Reset asserted mid-RUN: valve_on drops immediately (asynchronous), with no done pulse.

Optional Feature:
- Macro SPRINKLER_SEG7_EN.
- Defined: adds outputs seg_tens[6:0] and seg_units[6:0]. These are active-low 7-segment patterns for tens_digit and unit_digit, registered for one cycle of latency. When valve_on=0 both show blank (7'h7F), except during the DONE cycle.
- Not defined: the ports do not exist and there is no decode logic.

Decomposition:
- Package sprinkler_pkg holds:
  - state encoding constants: ST_IDLE, ST_RUN, ST_DONE, ST_REARM
  - BCD_W=4
  - BCD_MAX=4'd9
  - SEG_BLANK and the 0–9 seven-segment pattern constants
- One sub-module, sprinkler_edge_detect: 1-bit rising-edge detector, async active-low reset. Instantiated twice, for start and unit_borrow.

Test Plan:
- Reset mid-RUN (tens=2) → valve_on=0 and tens_digit=0 immediately; state=00; no done pulse.
- DURATION_TENS=3, start edge → next cycle: load_units=1 for 1 clk, tens_digit=3, valve_on=1, state=01. Four borrow edges → tens 2,1,0, then DONE with done=1 for 1 clk, valve_on=0, aborted=0.
- unit_borrow held high for 5 cycles in RUN (tens=3) → tens_digit=2 only (single decrement).
- stop and a borrow edge in the same cycle with tens=2 → DONE, aborted=1, tens_digit stays 2, valve_on=0 next cycle.
- start held high through DONE → state=REARM, no new load_units. Drop start, then raise it → new cycle starts and tens_digit=3.
- With SPRINKLER_SEG7_EN: RUN with tens=3, units=7 → seg_tens=7'b0110000, seg_units=7'b1111000, one clk after the digits change. In IDLE, both = 7'h7F.
